// File: rtl/rotate_left_seq_pkg.sv
// rtl/rotate_left_seq_pkg.sv - shared widths and FSM state encoding for the left rotator
package rotate_left_seq_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int AMT_WIDTH_DEF  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/rotate_left_step.sv
// rtl/rotate_left_step.sv - combinational rotate-left by one position
module rotate_left_step
    import rotate_left_seq_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    assign q = {d[DATA_WIDTH-2:0], d[DATA_WIDTH-1]};

endmodule

// File: rtl/rotate_left_seq.sv
// rtl/rotate_left_seq.sv - sequential left rotator, one position per clock, start/done handshake
module rotate_left_seq
    import rotate_left_seq_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int AMT_WIDTH  = AMT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [AMT_WIDTH-1:0]  amt,
    output logic [DATA_WIDTH-1:0] y,
    output logic                  ready,
    output logic                  busy,
    output logic                  done
);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] sr_q, sr_d;
    logic [DATA_WIDTH-1:0] sr_rot;
    logic [AMT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] y_q, y_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    rotate_left_step #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_step (
        .d(sr_q),
        .q(sr_rot)
    );

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d  = a;
                    cnt_d = amt;
                    if (amt == '0) begin
                        state_d = DONE;
                        y_d     = a;
                        done_d  = 1'b1;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                sr_d  = sr_rot;
                cnt_d = cnt_q - 1'b1;
                // y and done are loaded on the edge that enters DONE so both appear together
                if (cnt_q == AMT_WIDTH'(1)) begin
                    state_d = DONE;
                    y_d     = sr_rot;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign y     = y_q;
    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
